// File: rtl/uart_seq_pkg.sv
// Shared constants for the UART TX sequencer: register map, FSM encoding, CR byte.
package uart_seq_pkg;

    localparam int unsigned ADDR_SOFTRESET = 0;
    localparam int unsigned ADDR_DIV       = 1;
    localparam int unsigned ADDR_TXDATA    = 2;
    localparam int unsigned ADDR_TXEN      = 3;
    localparam int unsigned ADDR_TXREADY   = 4;

    localparam logic [7:0] CR_BYTE = 8'h0D;

    typedef enum logic [2:0] {
        ST_INIT_RST     = 3'd0,
        ST_INIT_RST_CLR = 3'd1,
        ST_INIT_DIV     = 3'd2,
        ST_INIT_TXEN    = 3'd3,
        ST_IDLE         = 3'd4,
        ST_POLL         = 3'd5,
        ST_SEND         = 3'd6
    } state_t;

endpackage

// File: rtl/uart_seq_fifo.sv
// Byte FIFO with registered full/empty/count flags; DEPTH must be a power of two.
module uart_seq_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               wdata,
    output logic [7:0]               head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_next;

    assign count_next = count + CNT_W'(push) - CNT_W'(pop);
    assign head       = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count_next;
            full  <= (count_next == CNT_W'(DEPTH));
            empty <= (count_next == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/uart_tx_sequencer.sv
// Bus master that initialises the UART and drains a byte FIFO through TX-ready polling.
// Optional poll timeout enabled by defining UART_SEQ_TIMEOUT_EN.
module uart_tx_sequencer
    import uart_seq_pkg::*;
#(
    parameter int unsigned UART_ADDR_W  = 3,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned FIFO_DEPTH   = 4,
`ifdef UART_SEQ_TIMEOUT_EN
    parameter int unsigned POLL_TIMEOUT = 1024,
`endif
    parameter int unsigned DIV_W        = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [DIV_W-1:0]       div,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [7:0]             in_data,
    output logic                   init_done,
    output logic                   busy,
    output logic                   cr_sent,
    output logic                   uart_valid,
    output logic [UART_ADDR_W-1:0] uart_addr,
    output logic [DATA_W-1:0]      uart_wdata,
    output logic                   uart_wstrb,
    input  logic [DATA_W-1:0]      uart_rdata,
`ifdef UART_SEQ_TIMEOUT_EN
    output logic                   timeout_err,
`endif
    input  logic                   uart_ready
);

    localparam int unsigned FIFO_CNT_W = $clog2(FIFO_DEPTH) + 1;

    state_t                 state;
    state_t                 state_next;
    logic                   done;
    logic                   push;
    logic                   pop;
    logic                   timeout_hit;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [7:0]             fifo_head;
    logic [FIFO_CNT_W-1:0]  fifo_count;
    logic [FIFO_CNT_W-1:0]  fifo_count_next;
    logic                   valid_d;
    logic [UART_ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0]      wdata_d;
    logic                   wstrb_d;
    logic                   unused_rdata_hi;

    assign done            = uart_valid & uart_ready;
    assign push            = in_valid & ~fifo_full;
    assign in_ready        = ~fifo_full;
    assign fifo_count_next = fifo_count + FIFO_CNT_W'(push) - FIFO_CNT_W'(pop);
    assign unused_rdata_hi = ^uart_rdata[DATA_W-1:1];

    uart_seq_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata (in_data),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

`ifdef UART_SEQ_TIMEOUT_EN
    localparam int unsigned POLL_CNT_W = $clog2(POLL_TIMEOUT + 1);
    logic [POLL_CNT_W-1:0] poll_cnt;

    // Consecutive failed TX-ready reads for the current head byte
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            poll_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (state == ST_IDLE && state_next == ST_POLL)
                poll_cnt <= '0;
            else if (state == ST_POLL && done && !uart_rdata[0])
                poll_cnt <= poll_cnt + POLL_CNT_W'(1);
            if (timeout_hit) timeout_err <= 1'b1;
        end
    end
`endif

    // State register plus registered bus request
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_INIT_RST;
            uart_valid <= 1'b0;
            uart_addr  <= '0;
            uart_wdata <= '0;
            uart_wstrb <= 1'b0;
        end else begin
            state      <= state_next;
            uart_valid <= valid_d;
            uart_addr  <= addr_d;
            uart_wdata <= wdata_d;
            uart_wstrb <= wstrb_d;
        end
    end

    always_comb begin
        state_next  = state;
        pop         = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            ST_INIT_RST:     if (done) state_next = ST_INIT_RST_CLR;
            ST_INIT_RST_CLR: if (done) state_next = ST_INIT_DIV;
            ST_INIT_DIV:     if (done) state_next = ST_INIT_TXEN;
            ST_INIT_TXEN:    if (done) state_next = ST_IDLE;
            ST_IDLE:         if (!fifo_empty) state_next = ST_POLL;
            ST_POLL: begin
                if (done) begin
                    if (uart_rdata[0]) begin
                        state_next = ST_SEND;
                    end
`ifdef UART_SEQ_TIMEOUT_EN
                    else if (poll_cnt == POLL_CNT_W'(POLL_TIMEOUT - 1)) begin
                        state_next  = ST_IDLE;
                        pop         = 1'b1;
                        timeout_hit = 1'b1;
                    end
`endif
                end
            end
            ST_SEND: begin
                if (done) begin
                    state_next = ST_IDLE;
                    pop        = 1'b1;
                end
            end
            default: state_next = ST_INIT_RST;
        endcase
    end

    // Launch a request for the upcoming state only after an idle cycle on the bus
    always_comb begin
        valid_d = uart_valid;
        addr_d  = uart_addr;
        wdata_d = uart_wdata;
        wstrb_d = uart_wstrb;
        if (uart_valid) begin
            if (uart_ready) valid_d = 1'b0;
        end else if (state_next != ST_IDLE) begin
            valid_d = 1'b1;
            wstrb_d = 1'b1;
            case (state_next)
                ST_INIT_RST: begin
                    addr_d  = UART_ADDR_W'(ADDR_SOFTRESET);
                    wdata_d = DATA_W'(1);
                end
                ST_INIT_RST_CLR: begin
                    addr_d  = UART_ADDR_W'(ADDR_SOFTRESET);
                    wdata_d = '0;
                end
                ST_INIT_DIV: begin
                    addr_d  = UART_ADDR_W'(ADDR_DIV);
                    wdata_d = DATA_W'(div);
                end
                ST_INIT_TXEN: begin
                    addr_d  = UART_ADDR_W'(ADDR_TXEN);
                    wdata_d = DATA_W'(1);
                end
                ST_POLL: begin
                    addr_d  = UART_ADDR_W'(ADDR_TXREADY);
                    wdata_d = '0;
                    wstrb_d = 1'b0;
                end
                ST_SEND: begin
                    addr_d  = UART_ADDR_W'(ADDR_TXDATA);
                    wdata_d = DATA_W'(fifo_head);
                end
                default: valid_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            init_done <= 1'b0;
            busy      <= 1'b0;
            cr_sent   <= 1'b0;
        end else begin
            init_done <= init_done | (state == ST_INIT_TXEN && done);
            busy      <= (fifo_count_next != '0) || valid_d;
            cr_sent   <= (state == ST_SEND) && done && (fifo_head == CR_BYTE);
        end
    end

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Directed bench for uart_tx_sequencer with a behavioural UART slave and transaction log.
// Timeout scenarios run only when UART_SEQ_TIMEOUT_EN is defined.
module tb_uart_tx_sequencer;

    localparam int unsigned UART_ADDR_W = 3;
    localparam int unsigned DATA_W      = 32;
    localparam int unsigned FIFO_DEPTH  = 4;
    localparam int unsigned DIV_W       = 16;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [DIV_W-1:0]       div;
    logic                   in_valid;
    logic                   in_ready;
    logic [7:0]             in_data;
    logic                   init_done;
    logic                   busy;
    logic                   cr_sent;
    logic                   uart_valid;
    logic [UART_ADDR_W-1:0] uart_addr;
    logic [DATA_W-1:0]      uart_wdata;
    logic                   uart_wstrb;
    logic [DATA_W-1:0]      uart_rdata;
    logic                   uart_ready;
`ifdef UART_SEQ_TIMEOUT_EN
    logic                   timeout_err;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic                   slave_en;
    logic                   tx_ready_default;
    logic                   tx_ready_q[$];
    logic [UART_ADDR_W-1:0] log_addr[$];
    logic [DATA_W-1:0]      log_wdata[$];
    logic                   log_wstrb[$];
    logic [DATA_W-1:0]      last_wr;
    int                     cr_cnt;
    logic [DATA_W-1:0]      cr_data;

    always #5 clk = ~clk;

    uart_tx_sequencer #(
        .UART_ADDR_W (UART_ADDR_W),
        .DATA_W      (DATA_W),
        .FIFO_DEPTH  (FIFO_DEPTH),
`ifdef UART_SEQ_TIMEOUT_EN
        .POLL_TIMEOUT(8),
`endif
        .DIV_W       (DIV_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .div        (div),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .init_done  (init_done),
        .busy       (busy),
        .cr_sent    (cr_sent),
        .uart_valid (uart_valid),
        .uart_addr  (uart_addr),
        .uart_wdata (uart_wdata),
        .uart_wstrb (uart_wstrb),
        .uart_rdata (uart_rdata),
`ifdef UART_SEQ_TIMEOUT_EN
        .timeout_err(timeout_err),
`endif
        .uart_ready (uart_ready)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // UART slave: answers one cycle after valid is seen, logs every completed transaction
    initial begin
        logic rd_bit;
        uart_ready = 1'b0;
        uart_rdata = '0;
        last_wr    = '0;
        forever begin
            @(negedge clk);
            uart_ready = 1'b0;
            if (!reset && slave_en && uart_valid) begin
                uart_ready = 1'b1;
                if (!uart_wstrb) begin
                    if (tx_ready_q.size() > 0) rd_bit = tx_ready_q.pop_front();
                    else                       rd_bit = tx_ready_default;
                    uart_rdata = {31'b0, rd_bit};
                end else begin
                    last_wr = uart_wdata;
                end
                log_addr.push_back(uart_addr);
                log_wdata.push_back(uart_wdata);
                log_wstrb.push_back(uart_wstrb);
            end
        end
    end

    initial begin
        cr_cnt  = 0;
        cr_data = '0;
        forever begin
            @(negedge clk);
            if (cr_sent) begin
                cr_cnt++;
                cr_data = last_wr;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic clear_log();
        log_addr.delete();
        log_wdata.delete();
        log_wstrb.delete();
    endtask

    // Called at a negedge; leaves at the negedge after the accepting edge
    task automatic push_byte(input logic [7:0] b);
        int n = 0;
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("push_ready", 32'(in_ready), 1);
        in_valid = 1'b1;
        in_data  = b;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_log(input int cnt);
        int n = 0;
        while (log_addr.size() < cnt && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("log_reached", 32'(log_addr.size() >= cnt), 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || uart_valid) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        check("idle_busy", 32'(busy), 0);
    endtask

    task automatic check_entry(input int i, input int addr, input logic [31:0] wdata, input logic wstrb);
        check($sformatf("addr[%0d]", i), 32'(log_addr[i]), 32'(addr));
        check($sformatf("wstrb[%0d]", i), 32'(log_wstrb[i]), 32'(wstrb));
        if (wstrb) check($sformatf("wdata[%0d]", i), log_wdata[i], wdata);
    endtask

    task automatic check_init(input logic [31:0] dv);
        wait_log(4);
        if (log_addr.size() >= 4) begin
            check_entry(0, 0, 32'h1, 1'b1);
            check_entry(1, 0, 32'h0, 1'b1);
            check_entry(2, 1, dv, 1'b1);
            check_entry(3, 3, 32'h1, 1'b1);
        end
        @(negedge clk);
        check("init_done_set", 32'(init_done), 1);
    endtask

    task automatic check_reset_vals(input string pfx);
        check({pfx, "_valid"},     32'(uart_valid), 0);
        check({pfx, "_addr"},      32'(uart_addr),  0);
        check({pfx, "_wdata"},     uart_wdata,      0);
        check({pfx, "_wstrb"},     32'(uart_wstrb), 0);
        check({pfx, "_in_ready"},  32'(in_ready),   1);
        check({pfx, "_init_done"}, 32'(init_done),  0);
        check({pfx, "_busy"},      32'(busy),       0);
        check({pfx, "_cr_sent"},   32'(cr_sent),    0);
`ifdef UART_SEQ_TIMEOUT_EN
        check({pfx, "_timeout"},   32'(timeout_err), 0);
`endif
    endtask

    initial begin
        logic [31:0] wr_seq[$];
        int          n_rd;
        reset            = 1'b1;
        div              = 16'h0364;
        in_valid         = 1'b0;
        in_data          = '0;
        slave_en         = 1'b1;
        tx_ready_default = 1'b1;

        repeat (3) @(negedge clk);
        check_reset_vals("rst");

        // Init sequence after reset release
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("first_valid", 32'(uart_valid), 1);
        check("first_addr", 32'(uart_addr), 0);
        check("init_done_early", 32'(init_done), 0);
        @(negedge clk);
        check_init(32'h0364);
        wait_idle();
        check("init_tx_count", 32'(log_addr.size()), 4);

        // Single byte, UART ready immediately
        clear_log();
        push_byte(8'h41);
        wait_idle();
        check("b41_count", 32'(log_addr.size()), 2);
        if (log_addr.size() == 2) begin
            check_entry(0, 4, 32'h0, 1'b0);
            check_entry(1, 2, 32'h41, 1'b1);
        end

        // TXREADY low three times then high
        clear_log();
        tx_ready_q = '{1'b0, 1'b0, 1'b0};
        push_byte(8'h55);
        wait_idle();
        check("retry_count", 32'(log_addr.size()), 5);
        if (log_addr.size() == 5) begin
            for (int i = 0; i < 4; i++) check_entry(i, 4, 32'h0, 1'b0);
            check_entry(4, 2, 32'h55, 1'b1);
        end

        // Fill FIFO while bus stalled, then release
        clear_log();
        slave_en = 1'b0;
        for (int i = 0; i < 4; i++) push_byte(8'h10 + 8'(i));
        check("full_in_ready", 32'(in_ready), 0);
        check("full_busy", 32'(busy), 1);
        slave_en = 1'b1;
        push_byte(8'h14);
        wait_idle();
        wr_seq.delete();
        n_rd = 0;
        for (int i = 0; i < log_addr.size(); i++) begin
            if (log_wstrb[i]) wr_seq.push_back(log_wdata[i]);
            else n_rd++;
        end
        check("burst_writes", 32'(wr_seq.size()), 5);
        check("burst_reads", 32'(n_rd), 5);
        for (int i = 0; i < 5; i++)
            if (i < wr_seq.size()) check($sformatf("burst_byte%0d", i), wr_seq[i], 32'h10 + 32'(i));
        check("cr_none_yet", 32'(cr_cnt), 0);

        // CR detection
        clear_log();
        push_byte(8'h49);
        push_byte(8'h0D);
        wait_idle();
        check("cr_pulses", 32'(cr_cnt), 1);
        check("cr_after_write", cr_data, 32'h0D);
        check("cr_low_after", 32'(cr_sent), 0);
        check("cr_tx_count", 32'(log_addr.size()), 4);

`ifdef UART_SEQ_TIMEOUT_EN
        // TXREADY stuck low: byte dropped after eight reads
        clear_log();
        tx_ready_default = 1'b0;
        push_byte(8'h77);
        wait_idle();
        check("to_err", 32'(timeout_err), 1);
        check("to_reads", 32'(log_addr.size()), 8);
        check("to_last_wr", last_wr, 32'h0D);
        tx_ready_default = 1'b1;
        clear_log();
        push_byte(8'h78);
        wait_idle();
        check("to_recover_count", 32'(log_addr.size()), 2);
        if (log_addr.size() == 2) check_entry(1, 2, 32'h78, 1'b1);
        check("to_sticky", 32'(timeout_err), 1);
`endif

        // Reset while a poll is outstanding
        slave_en = 1'b0;
        push_byte(8'h33);
        repeat (3) @(negedge clk);
        check("mid_valid_hi", 32'(uart_valid), 1);
        check("mid_addr_poll", 32'(uart_addr), 4);
        reset = 1'b1;
        #1;
        check_reset_vals("midrst");
        @(negedge clk);
        clear_log();
        div      = 16'h00AB;
        slave_en = 1'b1;
        reset    = 1'b0;
        check_init(32'h00AB);
        wait_idle();
        check("reinit_count", 32'(log_addr.size()), 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_sequencer.md
# uart_tx_sequencer

Bus-master controller that owns the UART's native CPU-style register port and sequences it autonomously. After reset it initialises the UART (soft reset, divider, TX enable), then drains a small byte FIFO fed by an on-chip requester, polling the TX-ready register before every data write. It sits between a stream producer (e.g. a console/log engine) and the UART's `valid/addr/wdata/wstrb/rdata/ready` slave port, replacing firmware-driven `putchar` polling.

## Interface
- `UART_ADDR_W`, 3: UART register address width.
- `DATA_W`, 32: native bus data width.
- `FIFO_DEPTH`, 4: byte FIFO depth; power of two, ≥2.
- `DIV_W`, 16: width of baud divider.
- `POLL_TIMEOUT`, 1024: failed TX-ready polls before a byte is dropped (only with timeout feature).

- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `div` in DIV_W: baud divider, sampled when INIT_DIV write issues.
- `in_valid` in 1: producer byte valid.
- `in_ready` out 1: FIFO not full.
- `in_data` in 8: byte to transmit.
- `init_done` out 1: UART initialisation complete (level).
- `busy` out 1: FIFO non-empty or bus transaction in flight.
- `cr_sent` out 1: one-cycle pulse when a 0x0D byte's TXDATA write completes.
- `uart_valid` out 1: bus request.
- `uart_addr` out UART_ADDR_W: register address.
- `uart_wdata` out DATA_W: write data.
- `uart_wstrb` out 1: 1 = write, 0 = read.
- `uart_rdata` in DATA_W: read data, valid in the `uart_ready` cycle.
- `uart_ready` in 1: slave completion strobe.
- `timeout_err` out 1: sticky poll-timeout flag (only with `UART_SEQ_TIMEOUT_EN`).

## Operation
- Register map (package constants): SOFTRESET=0, DIV=1, TXDATA=2, TXEN=3, TXREADY=4.
- FSM: INIT_RST (write 1 to SOFTRESET) → INIT_RST_CLR (write 0) → INIT_DIV (write `div`, zero-extended) → INIT_TXEN (write 1) → IDLE. IDLE → POLL when FIFO non-empty. POLL reads TXREADY: `rdata[0]`=1 → SEND; 0 → POLL again (new transaction next cycle). SEND writes `{24'b0, head}` to TXDATA, pops FIFO on completion → IDLE.
- `init_done` sets on INIT_TXEN completion, stays 1 until reset.
- FIFO accepts pushes at any state including during init; bytes wait until IDLE.
- Push when `in_valid & in_ready`. `in_ready` = !full from registered count; a pop in the same cycle does not enable a push while full.
- Simultaneous push and pop when non-full, non-empty: count unchanged, both pointers advance; pointers wrap modulo FIFO_DEPTH.

## Timing
- Reset values: `uart_valid`=0, `uart_addr`=0, `uart_wdata`=0, `uart_wstrb`=0, `in_ready`=1, `init_done`=0, `busy`=0, `cr_sent`=0, `timeout_err`=0; FSM in INIT_RST.
- First `uart_valid` asserts the cycle after `reset` deasserts.
- Handshake: `uart_valid`, `uart_addr`, `uart_wdata`, `uart_wstrb` registered, held stable until the cycle `uart_ready`=1; `uart_valid` low the following cycle (one idle cycle between transactions minimum). `uart_ready` while `uart_valid`=0 is ignored.
- Per-byte minimum latency from push into empty FIFO (UART ready): push cycle +1 POLL valid, +1 ready, +1 idle, SEND valid, ready ⇒ pop; 2 bus transactions.
- `cr_sent` pulses in the cycle after SEND completion of byte 0x0D.
- Reset mid-transaction: all state cleared asynchronously, in-flight request abandoned, FIFO emptied; init re-runs.

## Configuration
- `UART_SEQ_TIMEOUT_EN` defined: counter of consecutive failed POLL reads; on reaching POLL_TIMEOUT, head byte popped without write, `timeout_err` set (sticky until reset), FSM → IDLE. Counter clears on entry to POLL from IDLE.
- Undefined: POLL retries forever; `timeout_err` port and counter absent.

## Structure
- Package `uart_seq_pkg`: register address constants, FSM state encoding, CR constant 8'h0D.
- Sub-module `uart_seq_fifo`: parameterised byte FIFO (push/pop/full/empty/head), async reset.

## Test plan
- Reset release → exactly four writes in order: (0,1),(0,0),(1,`div`=0x0364),(3,1); `init_done`=1 after the fourth ready.
- Push 0x41 with bus slave returning TXREADY=1 → one read at addr 4, one write of 0x41 at addr 2, `busy` low afterwards.
- Slave returns TXREADY=0 three times then 1 → four reads at addr 4, then write; byte sent once.
- Push 5 bytes back-to-back with FIFO_DEPTH=4, UART stalled → `in_ready` low after fourth; all five transmitted in order once released.
- Send "I", "\r" → `cr_sent` single-cycle pulse only after 0x0D write completes.
- With `UART_SEQ_TIMEOUT_EN`, POLL_TIMEOUT=8, TXREADY stuck 0 → after 8 reads byte dropped, `timeout_err`=1; mid-poll `reset` → all outputs to reset values, init restarts.
